// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 packet router: default sizes, header field
// layout and output-port address encodings.
package router_pkg;

    localparam int DFLT_DATA_W = 8;
    localparam int DFLT_DEPTH  = 16;
    localparam int DFLT_ADDR_W = 4;

    // Header byte layout: [7:2] payload length, [1:0] destination port
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    typedef enum logic [1:0] {
        PORT_0   = 2'b00,
        PORT_1   = 2'b01,
        PORT_2   = 2'b10,
        PORT_INV = 2'b11
    } port_addr_e;

endpackage

// File: rtl/router_fifo.sv
// Output-port FIFO of the 1x3 router with header tagging and read-side packet
// tracking. Define ROUTER_FIFO_OCC_EN to add the occupancy output.
module router_fifo
    import router_pkg::*;
#(
    parameter int DATA_W = DFLT_DATA_W,
    parameter int DEPTH  = DFLT_DEPTH,
    parameter int ADDR_W = DFLT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              pkt_active
`ifdef ROUTER_FIFO_OCC_EN
    ,
    output logic [ADDR_W:0]   occupancy
`endif
);

    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  hdr_tag;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [6:0]        pkt_count;
    logic              flush;
    logic              wr_ok;
    logic              rd_ok;
    logic [DATA_W-1:0] rd_data;
    logic              rd_hdr;

    // Header carries payload length; the parity byte adds one more
    function automatic logic [6:0] hdr_count(input logic [DATA_W-1:0] hdr);
        return 7'(hdr[HDR_LEN_MSB:HDR_LEN_LSB]) + 7'd1;
    endfunction

    function automatic logic [6:0] sat_dec(input logic [6:0] cnt);
        return (cnt == 7'd0) ? 7'd0 : cnt - 7'd1;
    endfunction

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign pkt_active = (pkt_count != 7'd0);

    assign flush   = rst || soft_reset;
    assign wr_ok   = wr_en && !full && !flush;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[ADDR_W-1:0]];
    assign rd_hdr  = hdr_tag[rd_ptr[ADDR_W-1:0]];

    // Data array is never reset; pointers make stale entries unreachable
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pkt_count <= '0;
            dout      <= '0;
            hdr_tag   <= '0;
        end else begin
            if (wr_ok) begin
                hdr_tag[wr_ptr[ADDR_W-1:0]] <= lfd_state;
                wr_ptr                      <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                dout      <= rd_data;
                rd_ptr    <= rd_ptr + PTR_ONE;
                pkt_count <= rd_hdr ? hdr_count(rd_data) : sat_dec(pkt_count);
            end
        end
    end

`ifdef ROUTER_FIFO_OCC_EN
    assign occupancy = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: directed fill/packet/flush sequences
// followed by a random read/write phase.
module tb_router_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_reset;
    logic       wr_en;
    logic       rd_en;
    logic       lfd_state;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       pkt_active;
`ifdef ROUTER_FIFO_OCC_EN
    logic [4:0] occupancy;
`endif

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q [$];
    logic [7:0] exp_dout;
    logic [6:0] exp_cnt;

    router_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .soft_reset (soft_reset),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .lfd_state  (lfd_state),
        .din        (din),
        .dout       (dout),
        .full       (full),
        .empty      (empty),
        .pkt_active (pkt_active)
`ifdef ROUTER_FIFO_OCC_EN
        ,
        .occupancy  (occupancy)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus; the model is updated from pre-edge state
    task automatic cyc(input logic wr, input logic rd, input logic lfd,
                       input logic [7:0] d, input logic sr, input logic hr);
        logic       do_wr;
        logic       do_rd;
        logic [8:0] e;
        wr_en = wr; rd_en = rd; lfd_state = lfd; din = d;
        soft_reset = sr; rst = hr;
        do_rd = rd && (exp_q.size() != 0);
        do_wr = wr && (exp_q.size() != 16);
        if (sr || hr) begin
            exp_q.delete();
            exp_cnt  = 7'd0;
            exp_dout = 8'h00;
        end else begin
            if (do_rd) begin
                e = exp_q.pop_front();
                exp_dout = e[7:0];
                if (e[8]) exp_cnt = {1'b0, e[7:2]} + 7'd1;
                else if (exp_cnt != 7'd0) exp_cnt = exp_cnt - 7'd1;
            end
            if (do_wr) exp_q.push_back({lfd, d});
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; lfd_state = 1'b0; soft_reset = 1'b0; rst = 1'b0;
        chk("dout", dout, exp_dout);
        chk("empty", empty, exp_q.size() == 0);
        chk("full", full, exp_q.size() == 16);
        chk("pkt_active", pkt_active, exp_cnt != 7'd0);
`ifdef ROUTER_FIFO_OCC_EN
        chk("occupancy", occupancy, exp_q.size());
`endif
    endtask

    task automatic wr_byte(input logic lfd, input logic [7:0] d);
        cyc(1'b1, 1'b0, lfd, d, 1'b0, 1'b0);
    endtask

    task automatic rd_byte();
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        logic       r_wr, r_rd, r_lfd, r_sr;
        logic [7:0] r_d;
        rst = 1'b0; soft_reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        lfd_state = 1'b0; din = 8'h00;
        exp_dout = 8'h00; exp_cnt = 7'd0;

        // Reset
        @(negedge clk);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_dout", dout, 8'h00);

        // Fill to full, dropped 17th write, drain in order
        for (int i = 1; i <= 16; i++) wr_byte(1'b0, 8'(i));
        chk("fill_full", full, 1);
        wr_byte(1'b0, 8'hFF);
        chk("drop_full", full, 1);
        for (int i = 1; i <= 16; i++) rd_byte();
        chk("drain_empty", empty, 1);
        chk("drain_last", dout, 8'h10);

        // Stray read on empty holds dout
        rd_byte();
        chk("stray_hold", dout, 8'h10);

        // Packet tracking
        wr_byte(1'b1, 8'h0D);
        wr_byte(1'b0, 8'hA1);
        wr_byte(1'b0, 8'hA2);
        wr_byte(1'b0, 8'hA3);
        wr_byte(1'b0, 8'h5C);
        rd_byte();
        chk("hdr_active", pkt_active, 1);
        chk("hdr_count", dut.pkt_count, 4);
        for (int i = 0; i < 3; i++) rd_byte();
        chk("pre_parity_active", pkt_active, 1);
        rd_byte();
        chk("parity_dout", dout, 8'h5C);
        chk("parity_active", pkt_active, 0);

        // Simultaneous read/write with 8 stored
        for (int i = 0; i < 8; i++) wr_byte(1'b0, 8'h30 + 8'(i));
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 8'h40 + 8'(i), 1'b0, 1'b0);
        chk("simul_count", exp_q.size(), 8);
        chk("simul_dout", dout, 8'h33);
        for (int i = 0; i < 8; i++) rd_byte();

        // Soft reset mid-packet with concurrent write
        wr_byte(1'b1, 8'h0D);
        wr_byte(1'b0, 8'hA1);
        wr_byte(1'b0, 8'hA2);
        rd_byte();
        rd_byte();
        chk("mid_active", pkt_active, 1);
        cyc(1'b1, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0);
        chk("sr_empty", empty, 1);
        chk("sr_active", pkt_active, 0);
        chk("sr_dout", dout, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("sr_wr_discard", empty, 1);

        // Hard reset beats a concurrent write
        wr_byte(1'b0, 8'h11);
        cyc(1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 1'b1);
        chk("rst_prio", empty, 1);

`ifdef ROUTER_FIFO_OCC_EN
        for (int i = 0; i < 5; i++) wr_byte(1'b0, 8'h50 + 8'(i));
        rd_byte();
        rd_byte();
        chk("occ_3", occupancy, 3);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("occ_sr", occupancy, 0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r_wr  = 1'($urandom_range(0, 1));
            r_rd  = 1'($urandom_range(0, 1));
            r_lfd = ($urandom_range(0, 7) == 0);
            r_sr  = ($urandom_range(0, 99) == 0);
            r_d   = 8'($urandom);
            cyc(r_wr, r_rd, r_lfd, r_d, r_sr, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- One of three identical output-port FIFOs in the 1x3 packet router, directly downstream of the synchronizer.
- Accepts bytes when its wr_en bit from the synchronizer is set.
- Reports full/empty back to the synchronizer; the synchronizer derives vld_out from empty.
- Is flushed by the synchronizer's soft_reset timeout.
- Tags header bytes so the read side tracks packet boundaries and signals when a packet is in progress.

Parameters:
- DATA_W, 8, byte width of stored data (header, payload and parity bytes).
- DEPTH, 16, number of entries; must be a power of two.
- ADDR_W, 4, log2(DEPTH); pointers are ADDR_W+1 bits wide.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- soft_reset  input  1  synchronous flush from the synchronizer timeout; active-high.
- wr_en  input  1  write request; this FIFO's bit of the synchronizer wr_en bus.
- rd_en  input  1  read request from the external reader.
- lfd_state  input  1  marks the byte on din as a packet header.
- din  input  DATA_W  write data.
- dout  output  DATA_W  registered read data.
- full  output  1  no free entry.
- empty  output  1  no stored entry.
- pkt_active  output  1  high while read-side packet byte count is non-zero.

Behaviour:
- Storage: DEPTH entries of DATA_W+1 bits, {hdr_tag, data}. The tag is the lfd_state value captured at write time.
- Pointers: wr_ptr and rd_ptr, ADDR_W+1 bits each, wrap naturally modulo 2*DEPTH.
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) and the low ADDR_W bits are equal.
  - Both flags are combinational from registered pointers.
- Reset (rst=1):
  - wr_ptr=0, rd_ptr=0, pkt_count=0, dout=0, all hdr_tags cleared.
  - Resulting outputs: full=0, empty=1, pkt_active=0.
  - rst has priority over every other input.
- Soft reset (soft_reset=1, rst=0): identical effect to rst. Writes and reads in that cycle are discarded.
- Write: when wr_en=1 and full=0, mem[wr_ptr] <= {lfd_state, din} and wr_ptr increments. A write while full is silently dropped, with no state change.
- Read: when rd_en=1 and empty=0, dout <= mem[rd_ptr].data and rd_ptr increments. Read latency is 1 cycle: data appears on dout the edge after rd_en is sampled.
  - A read while empty is ignored; dout holds its value.
- Packet count (pkt_count, 7 bits):
  - On a read of an entry with hdr_tag=1: pkt_count <= data[7:2] + 1, covering payload length plus the parity byte. Bits [1:0] are the port address and are ignored here.
  - On a read of an entry with hdr_tag=0 while pkt_count != 0: pkt_count decrements.
  - A non-header read with pkt_count=0 leaves the count at 0 (stray byte, tolerated).
  - pkt_active = (pkt_count != 0), combinational.
- Simultaneous read and write:
  - Both are permitted when neither is blocked; the pointers update independently and occupancy is unchanged.
  - When full, only the read proceeds. When empty, only the write proceeds; the written data is not readable until the next cycle (no bypass).
- dout holds its last read value until the next successful read, rst or soft_reset.

Optional Feature:
- ROUTER_FIFO_OCC_EN defined: adds output port occupancy [ADDR_W:0] = wr_ptr - rd_ptr. It reads 0 after reset/soft_reset and DEPTH when full.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package router_pkg holds:
  - DATA_W, DEPTH, ADDR_W defaults.
  - Header field constants: HDR_ADDR_LSB=0, HDR_ADDR_MSB=1, HDR_LEN_LSB=2, HDR_LEN_MSB=7.
  - Port address encodings: 2'b00, 2'b01, 2'b10; 2'b11 is invalid.
- No sub-module: the storage array, pointers and packet counter live in router_fifo. The top level instantiates three copies.

Test Plan:
- Reset: assert rst 1 cycle -> empty=1, full=0, dout=0, pkt_active=0.
- Fill: write 16 bytes 0x01..0x10 -> full=1 after the 16th write. A 17th write of 0xFF is dropped. 16 reads return 0x01..0x10 in order, each one cycle after rd_en; empty=1 after the last.
- Packet tracking: write header 0x0D (lfd_state=1, length 3), payload 0xA1, 0xA2, 0xA3 and parity 0x5C.
  - Reading the header -> pkt_active=1, pkt_count=4.
  - pkt_count reaches 0 and pkt_active=0 on the edge that reads 0x5C.
- Simultaneous: with 8 entries stored, rd_en=wr_en=1 for 4 cycles -> occupancy stays 8, full=0, empty=0, read order preserved.
- Soft reset mid-packet: after the header plus 1 payload byte are read, pulse soft_reset with wr_en=1 -> empty=1, pkt_active=0, dout=0, and the concurrent write is discarded.
- ROUTER_FIFO_OCC_EN build: write 5, read 2 -> occupancy=3. Then soft_reset -> occupancy=0.
